led_mode_ctrl: RTL and testbench

Controller that owns the 16-LED bank and drives it from one of four display modes, stepped by a debounced centre button. Sits between the board switches/button and the LED pins, replacing the direct switch-to-LED wiring at top level. Includes the input synchronisers, the button debouncer and a shared animation tick.

---
 rtl/led_ctrl_pkg.sv | 32 +++
 rtl/btn_debounce.sv | 54 +++++
 rtl/led_mode_ctrl.sv | 91 +++++++++
 tb/tb_led_mode_ctrl.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_ctrl_pkg.sv
// Shared definitions for the LED mode controller: mode encodings, default
// timing constants and small helpers used by the controller datapath.
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_MIRROR = 2'd0,
        MODE_HOLD   = 2'd1,
        MODE_SCROLL = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_e;

    // 10 ms debounce and 0.25 s animation step at 100 MHz
    localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
    localparam int TICK_CYCLES_DEF     = 25_000_000;

    function automatic mode_e next_mode(input mode_e cur);
        mode_e nxt;
        case (cur)
            MODE_MIRROR: nxt = MODE_HOLD;
            MODE_HOLD:   nxt = MODE_SCROLL;
            MODE_SCROLL: nxt = MODE_BLINK;
            MODE_BLINK:  nxt = MODE_MIRROR;
            default:     nxt = MODE_MIRROR;
        endcase
        return nxt;
    endfunction

    function automatic logic [15:0] onehot16(input logic [3:0] pos);
        return 16'h0001 << pos;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button front end: 2-flop synchroniser, level debouncer and a one-cycle
// press pulse on each accepted 0->1 transition.
module btn_debounce
    import led_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] COUNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          din_meta;
    logic          din_s;
    logic          stable;
    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_meta <= 1'b0;
            din_s    <= 1'b0;
        end else begin
            din_meta <= din;
            din_s    <= din_meta;
        end
    end

    // Any return to the accepted level restarts the qualification window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable <= 1'b0;
            count  <= '0;
            press  <= 1'b0;
        end else begin
            press <= 1'b0;
            if (din_s != stable) begin
                if (count == COUNT_LAST) begin
                    stable <= din_s;
                    count  <= '0;
                    press  <= din_s;
                end else begin
                    count <= count + 1'b1;
                end
            end else begin
                count <= '0;
            end
        end
    end

endmodule

// File: rtl/led_mode_ctrl.sv
// LED bank controller: four display modes stepped by the debounced centre
// button, with a shared animation tick for the scroll and blink modes.
module led_mode_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int TICK_CYCLES     = TICK_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] sw,
    input  logic        btnc,
    output logic [15:0] led,
    output logic [1:0]  mode
);

    localparam int TW = $clog2(TICK_CYCLES);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

    logic [15:0]   sw_meta;
    logic [15:0]   sw_s;
    logic          press;
    logic          tick;
    logic [TW-1:0] tick_cnt;
    mode_e         state;
    logic [15:0]   hold_reg;
    logic [3:0]    scroll_pos;
    logic          blink_phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_meta <= '0;
            sw_s    <= '0;
        end else begin
            sw_meta <= sw;
            sw_s    <= sw_meta;
        end
    end

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btnc (
        .clk  (clk),
        .rst  (rst),
        .din  (btnc),
        .press(press)
    );

    assign tick = (tick_cnt == TICK_LAST);
    assign mode = state;

    // A press restarts the animation from its first frame; a tick landing in
    // the same cycle is dropped so the new mode always starts clean.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= MODE_MIRROR;
            hold_reg    <= '0;
            scroll_pos  <= '0;
            blink_phase <= 1'b1;
            tick_cnt    <= '0;
            led         <= '0;
        end else begin
            case (state)
                MODE_MIRROR: led <= sw_s;
                MODE_HOLD:   led <= hold_reg;
                MODE_SCROLL: led <= onehot16(scroll_pos);
                MODE_BLINK:  led <= blink_phase ? sw_s : 16'h0000;
                default:     led <= 16'h0000;
            endcase

            if (press) begin
                state       <= next_mode(state);
                tick_cnt    <= '0;
                scroll_pos  <= '0;
                blink_phase <= 1'b1;
                if (next_mode(state) == MODE_HOLD) begin
                    hold_reg <= sw_s;
                end
            end else begin
                tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
                if (tick && state == MODE_SCROLL) begin
                    scroll_pos <= sw_s[0] ? scroll_pos - 4'd1 : scroll_pos + 4'd1;
                end
                if (tick && state == MODE_BLINK) begin
                    blink_phase <= ~blink_phase;
                end
            end
        end
    end

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Self-checking bench for led_mode_ctrl with short debounce/tick periods and
// a cycle-level behavioural reference model.
module tb_led_mode_ctrl;

    localparam int DEB  = 4;
    localparam int TICK = 8;

    logic        clk;
    logic        rst;
    logic [15:0] sw;
    logic        btnc;
    logic [15:0] led;
    logic [1:0]  mode;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] exp_q[$];

    led_mode_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .TICK_CYCLES    (TICK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sw  (sw),
        .btnc(btnc),
        .led (led),
        .mode(mode)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    logic [15:0] m_sw_hist[$];
    logic        m_btn_hist[$];
    logic [15:0] m_led;
    logic [1:0]  m_mode;
    logic [15:0] m_hold;
    int          m_pos;
    logic        m_phase;
    int          m_tcnt;
    logic        m_level;
    int          m_run;
    logic        m_press;
    logic [15:0] m_sws;
    logic        m_bs;
    logic        m_tick;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_sw_hist  = '{16'h0000, 16'h0000};
                m_btn_hist = '{1'b0, 1'b0};
                m_led   = 16'h0000;
                m_mode  = 2'd0;
                m_hold  = 16'h0000;
                m_pos   = 0;
                m_phase = 1'b1;
                m_tcnt  = 0;
                m_level = 1'b0;
                m_run   = 0;
                m_press = 1'b0;
            end else begin
                // inputs seen by the logic are those sampled two edges ago
                m_sws = m_sw_hist[0];
                m_bs  = m_btn_hist[0];
                case (m_mode)
                    2'd0:    m_led = m_sws;
                    2'd1:    m_led = m_hold;
                    2'd2:    m_led = 16'h0001 << m_pos;
                    default: m_led = m_phase ? m_sws : 16'h0000;
                endcase
                m_tick = (m_tcnt == TICK - 1);
                if (m_press) begin
                    m_mode  = m_mode + 2'd1;
                    m_tcnt  = 0;
                    m_pos   = 0;
                    m_phase = 1'b1;
                    if (m_mode == 2'd1) m_hold = m_sws;
                end else begin
                    m_tcnt = m_tick ? 0 : m_tcnt + 1;
                    if (m_tick && m_mode == 2'd2)
                        m_pos = m_sws[0] ? (m_pos + 15) % 16 : (m_pos + 1) % 16;
                    if (m_tick && m_mode == 2'd3)
                        m_phase = !m_phase;
                end
                m_press = 1'b0;
                if (m_bs != m_level) begin
                    m_run = m_run + 1;
                    if (m_run == DEB) begin
                        m_level = m_bs;
                        m_run   = 0;
                        m_press = m_bs;
                    end
                end else begin
                    m_run = 0;
                end
                void'(m_sw_hist.pop_front());
                m_sw_hist.push_back(sw);
                void'(m_btn_hist.pop_front());
                m_btn_hist.push_back(btnc);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic press_button(input int hi, input int lo);
        btnc = 1'b1;
        repeat (hi) @(negedge clk);
        btnc = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        sw = 16'hA5C3;
        repeat (2) begin
            @(negedge clk);
            n_checks++;
            if (led !== 16'h0000 || mode !== 2'd0) begin
                n_fail++;
                $display("FAIL reset_state: led=%h mode=%0d, expected led=0000 mode=0", led, mode);
            end
        end
        sw  = 16'h0000;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if (led !== m_led || mode !== m_mode) begin
                n_fail++;
                $display("FAIL reset_model: led=%h mode=%0d, expected led=%h mode=%0d", led, mode, m_led, m_mode);
            end
        end
        sw = 16'hA5C3;
        repeat (2) @(negedge clk);
        n_checks++;
        if (led !== 16'h0000) begin
            n_fail++;
            $display("FAIL mirror_latency_early: led=%h, expected 0000 after 2 edges", led);
        end
        @(negedge clk);
        n_checks++;
        if (led !== 16'hA5C3 || mode !== 2'd0) begin
            n_fail++;
            $display("FAIL mirror_3rd_edge: led=%h mode=%0d, expected led=a5c3 mode=0", led, mode);
        end
    endtask

    task automatic test_bounce();
        int changes;
        logic [1:0] prev;
        sw = 16'h00FF;
        for (int i = 0; i < 12; i++) begin
            btnc = ((i / 2) % 2 == 0);
            @(negedge clk);
            n_checks++;
            if (mode !== 2'd0 || led !== m_led) begin
                n_fail++;
                $display("FAIL bounce_reject: mode=%0d led=%h, expected mode=0 led=%h", mode, led, m_led);
            end
        end
        btnc = 1'b0;
        repeat (8) @(negedge clk);
        n_checks++;
        if (mode !== 2'd0) begin
            n_fail++;
            $display("FAIL bounce_settled: mode=%0d, expected 0", mode);
        end
        changes = 0;
        prev = mode;
        btnc = 1'b1;
        for (int i = 0; i < 24; i++) begin
            if (i == 8) btnc = 1'b0;
            @(negedge clk);
            if (mode !== prev) changes++;
            prev = mode;
            n_checks++;
            if (mode !== m_mode || led !== m_led) begin
                n_fail++;
                $display("FAIL clean_press_model: mode=%0d led=%h, expected mode=%0d led=%h", mode, led, m_mode, m_led);
            end
        end
        n_checks++;
        if (changes != 1 || mode !== 2'd1) begin
            n_fail++;
            $display("FAIL clean_press: mode changes=%0d final mode=%0d, expected 1 change to mode 1", changes, mode);
        end
    endtask

    task automatic test_hold();
        sw = 16'hFFFF;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++;
            if (led !== 16'h00FF || mode !== 2'd1) begin
                n_fail++;
                $display("FAIL hold_latch: led=%h mode=%0d, expected led=00ff mode=1", led, mode);
            end
        end
    endtask

    task automatic test_scroll();
        bit seen;
        bit first;
        int since;
        logic [15:0] prev_led;
        logic [15:0] exp;
        sw = 16'h0000;
        press_button(6, 0);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (mode === 2'd2) seen = 1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL scroll_enter: mode=%0d, expected 2 within 20 cycles", mode);
        end
        for (int k = 0; k < 16; k++) exp_q.push_back(16'h0001 << k);
        exp_q.push_back(16'h0001);
        prev_led = led;
        first = 1;
        since = 0;
        for (int c = 0; c < 300 && exp_q.size() > 0; c++) begin
            @(negedge clk);
            since++;
            n_checks++;
            if (led !== m_led || mode !== m_mode) begin
                n_fail++;
                $display("FAIL scroll_model: led=%h mode=%0d, expected led=%h mode=%0d", led, mode, m_led, m_mode);
            end
            if (led !== prev_led) begin
                exp = exp_q.pop_front();
                n_checks++;
                if (led !== exp) begin
                    n_fail++;
                    $display("FAIL scroll_step: led=%h, expected %h", led, exp);
                end
                if (!first) begin
                    n_checks++;
                    if (since != TICK) begin
                        n_fail++;
                        $display("FAIL scroll_period: %0d cycles between steps, expected %0d", since, TICK);
                    end
                end
                first = 0;
                since = 0;
                prev_led = led;
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scroll_timeout: %0d steps left, expected 0", exp_q.size());
            exp_q.delete();
        end
        sw = 16'h0001;
        since = 0;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            since++;
            if (led !== prev_led) seen = 1;
        end
        n_checks++;
        if (!seen || led !== 16'h8000 || since != TICK) begin
            n_fail++;
            $display("FAIL scroll_reverse_wrap: led=%h after %0d cycles, expected 8000 after %0d", led, since, TICK);
        end
    endtask

    task automatic test_blink();
        bit seen;
        logic [15:0] exp;
        sw = 16'h1234;
        press_button(6, 0);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (mode === 2'd3) seen = 1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL blink_enter: mode=%0d, expected 3 within 20 cycles", mode);
        end
        for (int j = 1; j <= 32; j++) begin
            @(negedge clk);
            exp = (((j - 1) / TICK) % 2 == 0) ? 16'h1234 : 16'h0000;
            n_checks++;
            if (led !== exp || led !== m_led) begin
                n_fail++;
                $display("FAIL blink_pattern: cycle %0d led=%h, expected %h", j, led, exp);
            end
        end
        // align the accepted press with the cycle in which the tick fires
        seen = 0;
        for (int i = 0; i < 2 * TICK && !seen; i++) begin
            @(negedge clk);
            if (m_tcnt == 1) seen = 1;
        end
        press_button(6, 0);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (mode === 2'd0) seen = 1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL blink_tick_press: mode=%0d, expected 0", mode);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (led !== 16'h1234 || mode !== 2'd0 || led !== m_led) begin
            n_fail++;
            $display("FAIL blink_exit: led=%h mode=%0d, expected led=1234 mode=0", led, mode);
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_async_reset();
        bit seen;
        press_button(6, 8);
        press_button(6, 0);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (mode === 2'd2) seen = 1;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++;
            if (led !== m_led || mode !== m_mode || mode !== 2'd2) begin
                n_fail++;
                $display("FAIL async_pre_scroll: led=%h mode=%0d, expected led=%h mode=2", led, mode, m_led);
            end
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (led !== 16'h0000 || mode !== 2'd0) begin
            n_fail++;
            $display("FAIL async_reset: led=%h mode=%0d, expected led=0000 mode=0 without clock", led, mode);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_random();
        int run_left;
        run_left = 0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            n_checks++;
            if (led !== m_led || mode !== m_mode) begin
                n_fail++;
                $display("FAIL random_model: cycle %0d led=%h mode=%0d, expected led=%h mode=%0d", c, led, mode, m_led, m_mode);
            end
            if (rst) begin
                rst = 1'b0;
            end else if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1;
            end
            if ($urandom_range(0, 15) == 0) sw = 16'($urandom);
            if (run_left == 0) begin
                btnc = 1'($urandom_range(0, 1));
                run_left = $urandom_range(1, 10);
            end else begin
                run_left--;
            end
        end
        rst  = 1'b0;
        btnc = 1'b0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst  = 1'b0;
        sw   = 16'h0000;
        btnc = 1'b0;
        #2 rst = 1'b1;
        test_reset();
        test_bounce();
        test_hold();
        test_scroll();
        test_blink();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
